pc_sequencer: RTL and testbench

Multi-cycle fetch/execute controller that sequences the program counter register. It handshakes with instruction memory and with data memory for loads and stores. It generates the PC update enable, stops on halt, flags an instruction-fetch timeout, and counts retired instructions. It sits between the decode/branch logic and the PC register and drives that register's `in_en` input.

---
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/execute controller for the program counter.
// It handshakes with instruction and data memory, drives the PC register's
// update enable, stops on halt, latches a fetch-timeout fault and counts
// retired instructions.
module pc_sequencer #(
  parameter int IMEM_TIMEOUT = 16,
  parameter int RETIRE_W     = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                imem_ready,
  input  logic                dmem_done,
  input  logic                is_mem_op,
  input  logic                halt_req,
  input  logic                resume,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                instr_valid,
  output logic                pc_en,
  output logic                fault,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXECUTE  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_HALT     = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  // Last FETCH cycle index before a missing imem_ready becomes a fault.
  localparam logic [7:0] TO_LAST = 8'(IMEM_TIMEOUT - 1);

  state_t              r_state;
  logic [7:0]          r_toCount;
  logic [RETIRE_W-1:0] r_retired;
  logic                w_pcEn;
  logic                w_retire;

  // Mealy PC enable and retire strobe; halt resume steps the PC but does not retire.
  always_comb begin
    w_pcEn   = 1'b0;
    w_retire = 1'b0;
    unique case (r_state)
      S_EXECUTE: begin
        if (!halt_req && !is_mem_op) begin
          w_pcEn   = 1'b1;
          w_retire = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_done) begin
          w_pcEn   = 1'b1;
          w_retire = 1'b1;
        end
      end
      S_HALT: begin
        if (resume) begin
          w_pcEn = 1'b1;
        end
      end
      default: begin
        w_pcEn   = 1'b0;
        w_retire = 1'b0;
      end
    endcase
  end

  // State sequencing, fetch timeout counting and the retired-instruction counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_toCount <= 8'd0;
      r_retired <= '0;
    end else begin
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          r_toCount <= 8'd0;
          r_state   <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ready) begin
            r_toCount <= 8'd0;
            r_state   <= S_EXECUTE;
          end else if (r_toCount == TO_LAST) begin
            r_state <= S_FAULT;
          end else begin
            r_toCount <= r_toCount + 8'd1;
          end
        end
        S_EXECUTE: begin
          if (halt_req) begin
            r_state <= S_HALT;
          end else if (is_mem_op) begin
            r_state <= S_MEM_WAIT;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEM_WAIT: begin
          if (dmem_done) begin
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          if (resume) begin
            r_state <= S_FETCH;
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign dmem_req    = (r_state == S_MEM_WAIT);
  assign instr_valid = (r_state == S_EXECUTE) || (r_state == S_MEM_WAIT);
  assign halted      = (r_state == S_HALT);
  assign fault       = (r_state == S_FAULT);
  assign pc_en       = w_pcEn;
  assign retired     = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors drive pc_sequencer one cycle at a time;
// each vector's expected outputs go into a queue that a monitor drains on
// the falling clock edge.
module tb_pc_sequencer;

  logic       clock;
  logic       reset;
  logic       imemReady;
  logic       dmemDone;
  logic       isMemOp;
  logic       haltReq;
  logic       resumeIn;
  logic       imemReq;
  logic       dmemReq;
  logic       instrValid;
  logic       pcEn;
  logic       faultOut;
  logic       haltedOut;
  logic [3:0] retired;

  typedef struct {
    string      name;
    logic [5:0] outs;
    logic [3:0] ret;
  } exp_t;

  exp_t expQ[$];
  int   vectorsApplied = 0;
  int   miscompares    = 0;

  pc_sequencer #(
    .IMEM_TIMEOUT(4),
    .RETIRE_W    (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_ready (imemReady),
    .dmem_done  (dmemDone),
    .is_mem_op  (isMemOp),
    .halt_req   (haltReq),
    .resume     (resumeIn),
    .imem_req   (imemReq),
    .dmem_req   (dmemReq),
    .instr_valid(instrValid),
    .pc_en      (pcEn),
    .fault      (faultOut),
    .halted     (haltedOut),
    .retired    (retired)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one cycle of inputs just after the rising edge and queue what the outputs must be.
  // Output order: imem_req, dmem_req, instr_valid, pc_en, fault, halted.
  task automatic applyStimulus(input string name, input logic rst, input logic ir,
                               input logic dd, input logic mo, input logic hr,
                               input logic rs, input logic [5:0] eo, input logic [3:0] er);
    exp_t e;
    @(posedge clock);
    #1;
    reset     = rst;
    imemReady = ir;
    dmemDone  = dd;
    isMemOp   = mo;
    haltReq   = hr;
    resumeIn  = rs;
    e.name = name;
    e.outs = eo;
    e.ret  = er;
    expQ.push_back(e);
  endtask

  // Compare one queued expectation against the sampled outputs.
  task automatic checkOutput(input exp_t e);
    logic [5:0] act;
    act = {imemReq, dmemReq, instrValid, pcEn, faultOut, haltedOut};
    vectorsApplied++;
    if (act !== e.outs || retired !== e.ret) begin
      miscompares++;
      $display("[TB] FAIL %s: got outs=%b retired=%0d, expected outs=%b retired=%0d",
               e.name, act, retired, e.outs, e.ret);
    end
  endtask

  // Monitor: on every falling edge, pop and check the pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    reset     = 1'b1;
    imemReady = 1'b0;
    dmemDone  = 1'b0;
    isMemOp   = 1'b0;
    haltReq   = 1'b0;
    resumeIn  = 1'b0;

    // Reset state, then back-to-back ALU instructions.
    applyStimulus("reset",      1, 1, 0, 0, 0, 0, 6'b000000, 4'd0);
    applyStimulus("idle",       0, 1, 0, 0, 0, 0, 6'b000000, 4'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus($sformatf("alu_fetch%0d", k), 0, 1, 0, 0, 0, 0, 6'b100000, 4'(k));
      applyStimulus($sformatf("alu_exec%0d", k),  0, 1, 0, 0, 0, 0, 6'b001100, 4'(k));
    end
    applyStimulus("alu_ret4",   0, 1, 0, 0, 0, 0, 6'b100000, 4'd4);

    // Slow fetch (ready on the 4th = last legal cycle) then a load with a 2-cycle data wait.
    applyStimulus("ld_reset",   1, 0, 0, 0, 0, 0, 6'b000000, 4'd0);
    applyStimulus("ld_idle",    0, 0, 0, 0, 0, 0, 6'b000000, 4'd0);
    applyStimulus("ld_fetch0",  0, 0, 1, 0, 0, 0, 6'b100000, 4'd0);
    applyStimulus("ld_fetch1",  0, 0, 0, 0, 0, 0, 6'b100000, 4'd0);
    applyStimulus("ld_fetch2",  0, 0, 0, 0, 0, 0, 6'b100000, 4'd0);
    applyStimulus("ld_fetch3",  0, 1, 0, 0, 0, 0, 6'b100000, 4'd0);
    applyStimulus("ld_exec",    0, 0, 0, 1, 0, 0, 6'b001000, 4'd0);
    applyStimulus("ld_wait0",   0, 0, 0, 1, 0, 0, 6'b011000, 4'd0);
    applyStimulus("ld_wait1",   0, 0, 1, 0, 0, 0, 6'b011100, 4'd0);

    // Halt wins over mem-op, stays halted, resume steps the PC without retiring.
    applyStimulus("h_fetch",    0, 1, 0, 0, 0, 0, 6'b100000, 4'd1);
    applyStimulus("h_exec",     0, 0, 0, 1, 1, 0, 6'b001000, 4'd1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus($sformatf("h_hold%0d", k), 0, 1, 1, 0, 1, 0, 6'b000001, 4'd1);
    end
    applyStimulus("h_resume",   0, 0, 0, 0, 0, 1, 6'b000101, 4'd1);

    // Fetch timeout: four FETCH cycles without ready, then sticky fault.
    for (int k = 0; k < 4; k++) begin
      applyStimulus($sformatf("to_fetch%0d", k), 0, 0, 0, 0, 0, 0, 6'b100000, 4'd1);
    end
    for (int k = 0; k < 20; k++) begin
      applyStimulus($sformatf("flt%0d", k), 0, k[0], k[1], 0, k[2], k[0], 6'b000010, 4'd1);
    end
    applyStimulus("flt_reset",  1, 1, 0, 0, 0, 0, 6'b000000, 4'd0);
    applyStimulus("flt_idle",   0, 1, 0, 0, 0, 0, 6'b000000, 4'd0);
    applyStimulus("flt_fetch",  0, 1, 0, 0, 0, 0, 6'b100000, 4'd0);
    applyStimulus("flt_exec",   0, 1, 0, 0, 0, 0, 6'b001100, 4'd0);

    // Counter wrap: 17 retirements on a 4-bit counter, then reset in MEM_WAIT.
    applyStimulus("w_reset",    1, 1, 0, 0, 0, 0, 6'b000000, 4'd0);
    applyStimulus("w_idle",     0, 1, 0, 0, 0, 0, 6'b000000, 4'd0);
    for (int k = 0; k < 17; k++) begin
      applyStimulus($sformatf("w_fetch%0d", k), 0, 1, 0, 0, 0, 0, 6'b100000, 4'(k));
      applyStimulus($sformatf("w_exec%0d", k),  0, 1, 0, 0, 0, 0, 6'b001100, 4'(k));
    end
    applyStimulus("w_wrapped",  0, 1, 0, 0, 0, 0, 6'b100000, 4'd1);
    applyStimulus("w_memexec",  0, 0, 0, 1, 0, 0, 6'b001000, 4'd1);
    applyStimulus("w_memwait",  0, 0, 0, 0, 0, 0, 6'b011000, 4'd1);
    applyStimulus("w_midreset", 1, 0, 1, 0, 0, 0, 6'b000000, 4'd0);
    applyStimulus("w_release",  0, 1, 0, 0, 0, 0, 6'b000000, 4'd0);
    applyStimulus("w_refetch",  0, 1, 0, 0, 0, 0, 6'b100000, 4'd0);

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 10 && expQ.size() > 0; k++) begin
      @(posedge clock);
    end
    if (expQ.size() > 0) begin
      vectorsApplied++;
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
